omsp_bcd_serial_adder: RTL and testbench

Parametrised digit-serial decimal/binary adder for the openMSP430 ALU extension. It generalises the single-nibble DADD datapath to NDIGITS BCD digits, processing one 4-bit digit per clock with ripple carry held in a register. Operands are captured on a start handshake, and the block returns the result, C/Z/N flags and an invalid-BCD indication. It sits beside omsp_alu and is sequenced by the execution-unit state machine.

---
 rtl/omsp_bcd_pkg.sv | 30 +++
 rtl/omsp_bcd_if.sv | 31 +++
 rtl/omsp_bcd_digit_add.sv | 39 +++
 rtl/omsp_bcd_serial_adder.sv | 156 +++++++++++++++
 tb/tb_omsp_bcd_serial_adder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/omsp_bcd_pkg.sv
// Shared types and constants for the digit-serial BCD/binary adder.
package omsp_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;
    localparam int BCD_ADJ = 6;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single-digit operand still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/omsp_bcd_if.sv
// Start/operand/result bundle between the execution unit and the serial adder.
interface omsp_bcd_if
    import omsp_bcd_pkg::*;
#(
    parameter int NDIGITS = 4
);
    localparam int W = DIGIT_W * NDIGITS;

    logic         start_i;
    logic         mode_bin_i;
    logic [W-1:0] op_a_i;
    logic [W-1:0] op_b_i;
    logic         carry_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         carry_o;
    logic         zero_o;
    logic         neg_o;
    logic         invalid_o;

    modport master (
        output start_i, mode_bin_i, op_a_i, op_b_i, carry_i,
        input  busy_o, done_o, result_o, carry_o, zero_o, neg_o, invalid_o
    );

    modport slave (
        input  start_i, mode_bin_i, op_a_i, op_b_i, carry_i,
        output busy_o, done_o, result_o, carry_o, zero_o, neg_o, invalid_o
    );
endinterface

// File: rtl/omsp_bcd_digit_add.sv
// Combinational one-nibble adder with optional decimal adjust.
module omsp_bcd_digit_add
    import omsp_bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       bin,
    output logic [3:0] s,
    output logic       co,
    output logic       inv
);
    logic [4:0] w_sum;
    logic [3:0] w_adj;

    assign w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    assign w_adj = w_sum[3:0] + 4'(BCD_ADJ);

    // Digit result, carry and invalid-digit detect
    always_comb begin
        s   = w_sum[3:0];
        co  = 1'b0;
        inv = 1'b0;
        if (bin) begin
            s   = w_sum[3:0];
            co  = w_sum[4];
            inv = 1'b0;
        end else begin
            if (w_sum > 5'(BCD_MAX)) begin
                s  = w_adj;
                co = 1'b1;
            end else begin
                s  = w_sum[3:0];
                co = 1'b0;
            end
            inv = (a > 4'(BCD_MAX)) || (b > 4'(BCD_MAX));
        end
    end
endmodule

// File: rtl/omsp_bcd_serial_adder.sv
// Digit-serial decimal/binary adder: one nibble per clock, carry rippled through a register.
module omsp_bcd_serial_adder
    import omsp_bcd_pkg::*;
#(
    parameter int NDIGITS = 4
)(
    input  logic           mclk,
    input  logic           puc_rst,
    omsp_bcd_if.slave      bus
);
    localparam int W     = DIGIT_W * NDIGITS;
    localparam int CNT_W = cnt_width(NDIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_mode;
    logic             r_carry;
    logic             r_inv;

    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_invalid;

    logic             w_start_acc;
    logic             w_last;
    logic [3:0]       w_dsum;
    logic             w_dco;
    logic             w_dinv;
    logic [W-1:0]     w_sum_next;

    // Operands are shifted right each digit, so the active digit is always the low nibble.
    omsp_bcd_digit_add u_digit (
        .a   (r_a[3:0]),
        .b   (r_b[3:0]),
        .ci  (r_carry),
        .bin (r_mode),
        .s   (w_dsum),
        .co  (w_dco),
        .inv (w_dinv)
    );

    assign w_last     = (r_cnt == LAST);
    assign w_sum_next = (r_sum >> DIGIT_W) | (W'(w_dsum) << (W - DIGIT_W));

    // Next-state logic and start acceptance
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_acc = bus.start_i;
                if (bus.start_i) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE: begin
                w_start_acc = bus.start_i;
                if (bus.start_i) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next      = IDLE;
                w_start_acc = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shadow operands, digit counter, running carry and result shift register
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_inv   <= 1'b0;
        end else if (w_start_acc) begin
            r_cnt   <= '0;
            r_a     <= bus.op_a_i;
            r_b     <= bus.op_b_i;
            r_sum   <= '0;
            r_mode  <= bus.mode_bin_i;
            r_carry <= bus.carry_i;
            r_inv   <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt   <= w_last ? r_cnt : r_cnt + CNT_W'(1);
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_sum   <= w_sum_next;
            r_carry <= w_dco;
            r_inv   <= r_inv | w_dinv;
        end
    end

    // Registered status and result; results update only on the edge entering DONE
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_busy <= (w_next == RUN);
            r_done <= (w_next == DONE);
            if ((r_state == RUN) && w_last) begin
                r_result  <= w_sum_next;
                r_cout    <= w_dco;
                r_zero    <= (w_sum_next == '0);
                r_neg     <= w_sum_next[W-1];
                r_invalid <= r_mode ? 1'b0 : (r_inv | w_dinv);
            end
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.result_o  = r_result;
    assign bus.carry_o   = r_cout;
    assign bus.zero_o    = r_zero;
    assign bus.neg_o     = r_neg;
    assign bus.invalid_o = r_invalid;
endmodule

// File: tb/tb_omsp_bcd_serial_adder.sv
// Scoreboard bench for the digit-serial BCD/binary adder (NDIGITS = 4).
module tb_omsp_bcd_serial_adder;
    localparam int ND = 4;
    localparam int W  = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         n;
        logic         inv;
    } exp_t;

    logic mclk = 1'b0;
    logic puc_rst;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 mclk = ~mclk;

    omsp_bcd_if #(.NDIGITS(ND)) bus ();

    omsp_bcd_serial_adder #(.NDIGITS(ND)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus)
    );

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic inv);
        exp_t e;
        e.res = r; e.c = c; e.z = (r == '0); e.n = r[W-1]; e.inv = inv;
        return e;
    endfunction

    function automatic exp_t model(input logic bin, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic [4:0]   s;
        logic [3:0]   da, db;
        logic         c, inv;
        r = '0; c = ci; inv = 1'b0;
        if (bin) begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r = full[W-1:0];
            c = full[W];
        end else begin
            for (int k = 0; k < ND; k++) begin
                da = a[4*k +: 4];
                db = b[4*k +: 4];
                s  = {1'b0, da} + {1'b0, db} + {4'b0000, c};
                if (s > 5'd9) begin
                    r[4*k +: 4] = 4'(s + 5'd6);
                    c = 1'b1;
                end else begin
                    r[4*k +: 4] = s[3:0];
                    c = 1'b0;
                end
                if (da > 4'd9 || db > 4'd9) inv = 1'b1;
            end
        end
        return mk(r, c, inv);
    endfunction

    function automatic exp_t observe();
        exp_t g;
        g.res = bus.result_o; g.c = bus.carry_o; g.z = bus.zero_o;
        g.n = bus.neg_o; g.inv = bus.invalid_o;
        return g;
    endfunction

    // Entered and left at #1 after a rising edge; returns cycles from start to done.
    task automatic run_op(input logic bin, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, output int lat, output logic busy_ok, output exp_t got);
        bus.mode_bin_i = bin; bus.op_a_i = a; bus.op_b_i = b; bus.carry_i = ci;
        bus.start_i = 1'b1;
        @(posedge mclk); #1;
        bus.start_i = 1'b0;
        lat = 1; busy_ok = 1'b1;
        while (!bus.done_o && lat < 20) begin
            if (!bus.busy_o) busy_ok = 1'b0;
            @(posedge mclk); #1;
            lat++;
        end
        if (bus.busy_o) busy_ok = 1'b0;
        got = observe();
    endtask

    task automatic op_and_check(input string name, input logic bin, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic ci, input exp_t e_push);
        int   lat;
        logic bok;
        exp_t got, e;
        exp_q.push_back(e_push);
        run_op(bin, a, b, ci, lat, bok, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got res=%h c=%b z=%b n=%b inv=%b, expected res=%h c=%b z=%b n=%b inv=%b",
                     name, got.res, got.c, got.z, got.n, got.inv, e.res, e.c, e.z, e.n, e.inv);
        end
        checks++;
        if (lat !== 5 || bok !== 1'b1) begin
            errors++;
            $display("FAIL %s_timing: got latency=%0d busy_ok=%b, expected latency=5 busy_ok=1",
                     name, lat, bok);
        end
    endtask

    task automatic test_reset();
        puc_rst = 1'b1;
        bus.start_i = 1'b0; bus.mode_bin_i = 1'b0; bus.op_a_i = '0; bus.op_b_i = '0; bus.carry_i = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        checks++;
        if ({bus.busy_o, bus.done_o, observe()} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h, expected all zero",
                     bus.busy_o, bus.done_o, bus.result_o);
        end
        puc_rst = 1'b0;
        @(posedge mclk); #1;
    endtask

    task automatic test_bcd_basic();
        op_and_check("bcd_1234_5678", 1'b0, 16'h1234, 16'h5678, 1'b0, mk(16'h6912, 1'b0, 1'b0));
        op_and_check("bcd_9999_0001", 1'b0, 16'h9999, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        op_and_check("bcd_carry_in",  1'b0, 16'h0000, 16'h0000, 1'b1, mk(16'h0001, 1'b0, 1'b0));
    endtask

    task automatic test_binary();
        op_and_check("bin_ffff_0001", 1'b1, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        op_and_check("bin_7fff_0001", 1'b1, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b0));
    endtask

    task automatic test_invalid();
        op_and_check("bcd_invalid", 1'b0, 16'h00A0, 16'h0000, 1'b0, mk(16'h0100, 1'b0, 1'b1));
        op_and_check("bin_no_inv",  1'b1, 16'h00A0, 16'h0000, 1'b0, mk(16'h00A0, 1'b0, 1'b0));
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         bin, ci;
        for (int i = 0; i < 10; i++) begin
            bin = 1'($urandom_range(0, 1));
            ci  = 1'($urandom_range(0, 1));
            for (int k = 0; k < ND; k++) begin
                a[4*k +: 4] = 4'($urandom_range(0, (i == 7) ? 15 : 9));
                b[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if (bin) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            op_and_check("random", bin, a, b, ci, model(bin, a, b, ci));
        end
    endtask

    task automatic test_back_to_back();
        int   last_done, ndone;
        logic busy_ok;
        exp_t e, got;
        bus.mode_bin_i = 1'b0; bus.op_a_i = 16'h0250; bus.op_b_i = 16'h0749; bus.carry_i = 1'b0;
        bus.start_i = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(16'h0999, 1'b0, 1'b0));
        @(posedge mclk); #1;
        last_done = 0; ndone = 0; busy_ok = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) bus.start_i = 1'b0;
            if (bus.busy_o === bus.done_o) busy_ok = 1'b0;
            if (bus.done_o) begin
                ndone++;
                checks++;
                if (i - last_done !== 5) begin
                    errors++;
                    $display("FAIL b2b_period: got %0d cycles, expected 5", i - last_done);
                end
                last_done = i;
                e = exp_q.pop_front();
                got = observe();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL b2b_result: got res=%h c=%b, expected res=%h c=%b",
                             got.res, got.c, e.res, e.c);
                end
            end
            if (i < 15) begin
                @(posedge mclk); #1;
            end
        end
        checks++;
        if (ndone !== 3 || busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pulses: got dones=%0d busy_ok=%b, expected dones=3 busy_ok=1",
                     ndone, busy_ok);
        end
        @(posedge mclk); #1;
    endtask

    task automatic test_ignore_mid_run();
        int   lat;
        exp_t e, got;
        exp_q.push_back(mk(16'h3333, 1'b0, 1'b0));
        bus.mode_bin_i = 1'b0; bus.op_a_i = 16'h1111; bus.op_b_i = 16'h2222; bus.carry_i = 1'b0;
        bus.start_i = 1'b1;
        @(posedge mclk); #1;
        bus.start_i = 1'b0;
        @(posedge mclk); #1;
        bus.mode_bin_i = 1'b1; bus.op_a_i = 16'h9999; bus.op_b_i = 16'h9999; bus.carry_i = 1'b1;
        bus.start_i = 1'b1;
        @(posedge mclk); #1;
        bus.start_i = 1'b0;
        lat = 3;
        while (!bus.done_o && lat < 20) begin
            @(posedge mclk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        got = observe();
        checks++;
        if (got !== e || lat !== 5) begin
            errors++;
            $display("FAIL mid_run_start: got res=%h inv=%b latency=%0d, expected res=%h inv=%b latency=5",
                     got.res, got.inv, lat, e.res, e.inv);
        end
        @(posedge mclk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        bus.mode_bin_i = 1'b0; bus.op_a_i = 16'h4444; bus.op_b_i = 16'h4444; bus.carry_i = 1'b0;
        bus.start_i = 1'b1;
        @(posedge mclk); #1;
        bus.start_i = 1'b0;
        @(posedge mclk); #2;
        puc_rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy_o, bus.done_o, observe()} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b res=%h c=%b, expected all zero",
                     bus.busy_o, bus.done_o, bus.result_o, bus.carry_o);
        end
        @(posedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge mclk); #1;
            if (bus.done_o || bus.busy_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles, expected 0", seen);
        end
        op_and_check("after_reset", 1'b0, 16'h4444, 16'h4444, 1'b0, mk(16'h8888, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bcd_basic();
        test_binary();
        test_invalid();
        test_random();
        test_back_to_back();
        test_ignore_mid_run();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
